attention_row_stream_mx: RTL



---
 rtl/attention_row_stream_mx.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/attention_row_stream_mx.sv
// Streams one query row of MX-int attention with a running-max base-2 softmax; ATTN_ROW_STREAM_MASK_EN adds kv_mask_i.
// Latency: KV rows accepted one per cycle; r_valid_o rises 1+D_V*MAN_W cycles after the last KV accept.
// Backpressure: result held stable until r_ready_i; Q and KV are refused while dividing or holding a result.
module attention_row_stream_mx #(
    parameter int D_KQ       = 8,
    parameter int D_V        = 8,
    parameter int MAN_W      = 8,
    parameter int SCALE_W    = 8,
    parameter int SCALE_BIAS = 127,
    parameter int P_FRAC     = 8,
    parameter int MAX_SKV    = 64,
    parameter int ACC_W      = 32
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         q_valid_i,
    output logic                         q_ready_o,
    input  logic [D_KQ-1:0][MAN_W-1:0]   q_i,
    input  logic [SCALE_W-1:0]           s_q_i,
    input  logic [SCALE_W-1:0]           s_k_i,
    input  logic [SCALE_W-1:0]           s_v_i,
    input  logic                         kv_valid_i,
    output logic                         kv_ready_o,
    input  logic [D_KQ-1:0][MAN_W-1:0]   k_i,
    input  logic [D_V-1:0][MAN_W-1:0]    v_i,
    input  logic                         kv_last_i,
`ifdef ATTN_ROW_STREAM_MASK_EN
    input  logic                         kv_mask_i,
`endif
    output logic                         r_valid_o,
    input  logic                         r_ready_i,
    output logic [D_V-1:0][MAN_W-1:0]    r_o,
    output logic [SCALE_W-1:0]           s_r_o
);

    localparam int SH_W   = SCALE_W + 4;
    localparam int DF_W   = ACC_W + 1;
    localparam int RS_W   = $clog2(ACC_W);
    localparam int CNT_W  = $clog2(MAN_W);
    localparam int J_W    = (D_V > 1) ? $clog2(D_V) : 1;
    localparam int WIDE_W = ACC_W + MAN_W;
    localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [P_FRAC:0]         P_ONE   = {{P_FRAC{1'b0}}, 1'b1};

    if (ACC_W < 2*MAN_W + $clog2(D_KQ) + 1 || ACC_W < MAN_W + P_FRAC + $clog2(MAX_SKV) + 1) begin : g_acc_w_check
        $error("attention_row_stream_mx: ACC_W too narrow for score or accumulator range");
    end

    typedef enum logic [1:0] {IDLE, KV, DIV, OUT} state_t;
    state_t state, state_nxt;

    logic [D_KQ-1:0][MAN_W-1:0] q_r;
    logic [SCALE_W-1:0]         sv_r;
    logic signed [SH_W-1:0]     sh_r, sh_calc;
    logic signed [ACC_W-1:0]    m_r;
    logic [ACC_W-1:0]           sum_r;
    logic signed [ACC_W-1:0]    acc_r [D_V];
    logic                       have_max;
    logic [J_W-1:0]             j_r;
    logic [CNT_W-1:0]           cnt_r;
    logic [ACC_W-1:0]           rem_r;
    logic [MAN_W-2:0]           quo_r;

    logic q_fire, kv_fire, r_fire, kv_use, div_wr, div_done;

    assign q_fire  = q_valid_i && q_ready_o;
    assign kv_fire = kv_valid_i && kv_ready_o;
    assign r_fire  = r_valid_o && r_ready_i;
`ifdef ATTN_ROW_STREAM_MASK_EN
    assign kv_use  = kv_fire && !kv_mask_i;
`else
    assign kv_use  = kv_fire;
`endif
    assign div_wr   = (state == DIV) && (cnt_r == CNT_W'(MAN_W-1));
    assign div_done = div_wr && (j_r == J_W'(D_V-1));

    // Net right shift applied to the raw dot product: sqrt(D_KQ) scaling minus the combined exponent.
    assign sh_calc = SH_W'($clog2(D_KQ) / 2) - SH_W'(s_q_i) - SH_W'(s_k_i) + SH_W'(2 * SCALE_BIAS);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (q_fire) state_nxt = KV;
            KV:      if (kv_fire && kv_last_i) state_nxt = DIV;
            DIV:     if (div_done) state_nxt = OUT;
            OUT:     if (r_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            q_ready_o  <= 1'b0;
            kv_ready_o <= 1'b0;
            r_valid_o  <= 1'b0;
        end else begin
            state      <= state_nxt;
            q_ready_o  <= (state_nxt == IDLE);
            kv_ready_o <= (state_nxt == KV);
            r_valid_o  <= (state_nxt == OUT);
        end
    end

    logic signed [ACC_W-1:0] score, prod, t_val, shl, shl_back;
    logic [SH_W-1:0]         amt;

    always_comb begin
        score = '0;
        prod  = '0;
        for (int i = 0; i < D_KQ; i++) begin
            prod  = ACC_W'($signed(q_r[i])) * ACC_W'($signed(k_i[i]));
            score = score + prod;
        end
    end

    // Left shifts saturate so an oversized exponent cannot wrap a score past the running max.
    always_comb begin
        amt      = '0;
        shl      = '0;
        shl_back = '0;
        t_val    = score;
        if (!sh_r[SH_W-1]) begin
            amt   = (sh_r > SH_W'(ACC_W-1)) ? SH_W'(ACC_W-1) : sh_r;
            t_val = score >>> amt;
        end else begin
            amt      = (-sh_r > SH_W'(ACC_W)) ? SH_W'(ACC_W) : -sh_r;
            shl      = score <<< amt;
            shl_back = shl >>> amt;
            if (shl_back != score) t_val = score[ACC_W-1] ? SAT_MIN : SAT_MAX;
            else                   t_val = shl;
        end
    end

    logic signed [DF_W-1:0]  diff, e_val;
    logic                    new_max;
    logic [P_FRAC:0]         p_val;
    logic [RS_W-1:0]         rs;
    logic signed [ACC_W-1:0] p_s;

    assign diff    = DF_W'(t_val) - DF_W'(m_r);
    assign e_val   = DF_W'(m_r) - DF_W'(t_val);
    assign new_max = !have_max || (!diff[DF_W-1] && (diff != '0));
    assign p_s     = $signed(ACC_W'(p_val));

    always_comb begin
        p_val = '0;
        rs    = '0;
        if (new_max) begin
            p_val = P_ONE << P_FRAC;
            if (have_max) rs = (diff >= DF_W'(ACC_W-1)) ? RS_W'(ACC_W-1) : diff[RS_W-1:0];
        end else if (e_val <= DF_W'(P_FRAC)) begin
            p_val = P_ONE << (DF_W'(P_FRAC) - e_val);
        end
    end

    logic signed [ACC_W-1:0] acc_sel;
    logic [ACC_W-1:0]        rem_cur, rem_nxt;
    logic [WIDE_W-1:0]       dsh;
    logic [MAN_W-2:0]        quo_nxt;
    logic [CNT_W-1:0]        bit_idx;
    logic [MAN_W-1:0]        mag, res;

    // Restoring division of |acc_j| by sum, quotient MSB first; the load of |acc_j| folds into step 0.
    always_comb begin
        acc_sel = acc_r[j_r];
        rem_cur = (cnt_r == '0) ? (acc_sel[ACC_W-1] ? -acc_sel : acc_sel) : rem_r;
        bit_idx = CNT_W'(MAN_W-2) - cnt_r;
        dsh     = WIDE_W'(sum_r) << bit_idx;
        quo_nxt = (cnt_r == '0) ? '0 : quo_r;
        rem_nxt = rem_cur;
        if (!div_wr && (WIDE_W'(rem_cur) >= dsh)) begin
            rem_nxt          = rem_cur - dsh[ACC_W-1:0];
            quo_nxt[bit_idx] = 1'b1;
        end
        mag = {1'b0, quo_r};
        res = (sum_r == '0) ? '0 : (acc_sel[ACC_W-1] ? -mag : mag);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            q_r      <= '0;
            sv_r     <= '0;
            sh_r     <= '0;
            m_r      <= '0;
            sum_r    <= '0;
            have_max <= 1'b0;
            for (int j = 0; j < D_V; j++) acc_r[j] <= '0;
            j_r      <= '0;
            cnt_r    <= '0;
            rem_r    <= '0;
            quo_r    <= '0;
            r_o      <= '0;
            s_r_o    <= '0;
        end else begin
            if (q_fire) begin
                q_r      <= q_i;
                sv_r     <= s_v_i;
                sh_r     <= sh_calc;
                sum_r    <= '0;
                have_max <= 1'b0;
                j_r      <= '0;
                cnt_r    <= '0;
                for (int j = 0; j < D_V; j++) acc_r[j] <= '0;
            end
            if (kv_use) begin
                have_max <= 1'b1;
                if (new_max) m_r <= t_val;
                sum_r <= (sum_r >> rs) + ACC_W'(p_val);
                for (int j = 0; j < D_V; j++)
                    acc_r[j] <= (acc_r[j] >>> rs) + p_s * ACC_W'($signed(v_i[j]));
            end
            if (state == DIV) begin
                if (div_wr) begin
                    r_o[j_r] <= res;
                    cnt_r    <= '0;
                    j_r      <= j_r + 1'b1;
                    if (div_done) s_r_o <= sv_r;
                end else begin
                    cnt_r <= cnt_r + 1'b1;
                    rem_r <= rem_nxt;
                    quo_r <= quo_nxt;
                end
            end
        end
    end

endmodule
